// File: rtl/mode_select.sv
// mode_select: push-button front end for the mode-driven counter.
// Synchronizes a raw button, debounces it, and toggles a registered mode
// level once per accepted press, with a one-cycle press strobe.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | debounced level low, synchronized input low
// DEB_HI | input high, counting toward accepting a press
// HELD   | debounced level high, press already accepted
// DEB_LO | input low, counting toward accepting the release
module mode_select #(
   parameter int   STABLE_CYCLES = 4,
   parameter logic RESET_MODE    = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   input  logic lock,
   output logic mode,
   output logic press_pulse,
   output logic btn_db
);

   localparam int CNT_W = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DEB_HI = 2'd1;
   localparam logic [1:0] HELD   = 2'd2;
   localparam logic [1:0] DEB_LO = 2'd3;

   logic             s1_q, s2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             btn_db_q, btn_db_d;
   logic [1:0]       state_q, state_d;
   logic             mode_q, mode_d;
   logic             press_pulse_q, press_pulse_d;
   logic             accept;

   // Two-flop synchronizer for the asynchronous button input.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= btn;
         s2_q <= s1_q;
      end
   end

   // Debounce counter: any agreement with the debounced level clears it, so
   // short glitches restart the count rather than pausing it.
   always_comb begin
      cnt_d    = cnt_q;
      btn_db_d = btn_db_q;
      if (s2_q == btn_db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         btn_db_d = s2_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Press FSM next state; a press is accepted on the DEB_HI expiry edge.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (s2_q) state_d = DEB_HI;
         end
         DEB_HI: begin
            if (!s2_q) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_MAX) begin
               state_d = HELD;
               accept  = 1'b1;
            end
         end
         HELD: begin
            if (!s2_q) state_d = DEB_LO;
         end
         DEB_LO: begin
            if (s2_q) begin
               state_d = HELD;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output next values; lock only matters on the accepting edge.
   always_comb begin
      press_pulse_d = accept;
      mode_d        = mode_q;
      if (accept && !lock) mode_d = ~mode_q;
   end

   // State, debounce and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q         <= '0;
         btn_db_q      <= 1'b0;
         state_q       <= IDLE;
         mode_q        <= RESET_MODE;
         press_pulse_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         btn_db_q      <= btn_db_d;
         state_q       <= state_d;
         mode_q        <= mode_d;
         press_pulse_q <= press_pulse_d;
      end
   end

   assign mode        = mode_q;
   assign press_pulse = press_pulse_q;
   assign btn_db      = btn_db_q;

endmodule

// File: tb/tb_mode_select.sv
// Scoreboard bench for mode_select: stimulus pushes the expected mode and
// acceptance cycle of each press; a monitor pops on every press_pulse.
module tb_mode_select;

   localparam int S = 4;

   logic clk = 1'b0;
   logic reset;
   logic btn;
   logic lock;
   logic mode;
   logic press_pulse;
   logic btn_db;

   typedef struct {
      logic mode;
      int   cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   mode_select #(.STABLE_CYCLES(S), .RESET_MODE(1'b0)) dut (
      .clk        (clk),
      .reset      (reset),
      .btn        (btn),
      .lock       (lock),
      .mode       (mode),
      .press_pulse(press_pulse),
      .btn_db     (btn_db)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expectation per strobe, flags stray mode changes.
   logic prev_pp   = 1'b0;
   logic prev_mode = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         if (press_pulse) begin
            chk("pulse_width", int'(prev_pp), 0);
            if (sb.size() == 0) begin
               chk("unexpected_pulse", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("mode_on_accept", int'(mode), int'(e.mode));
               chk("btn_db_on_accept", int'(btn_db), 1);
               chk("accept_cycle", cyc, e.cyc);
            end
         end else if (mode != prev_mode) begin
            chk("mode_change_without_pulse", int'(mode), int'(prev_mode));
         end
      end
      prev_pp   = press_pulse;
      prev_mode = mode;
   end

   task automatic hold(input logic v, input int n);
      btn = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic exp_mode, input int n);
      exp_t e;
      e.mode = exp_mode;
      e.cyc  = cyc + S + 2;
      sb.push_back(e);
      hold(1'b1, n);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic [5:0] bounce;
      reset = 1'b1;
      btn   = 1'b0;
      lock  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mode", int'(mode), 0);
      chk("rst_pulse", int'(press_pulse), 0);
      chk("rst_btn_db", int'(btn_db), 0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_mode", int'(mode), 0);

      // clean press, then release
      press(1'b1, 10);
      chk("held_btn_db", int'(btn_db), 1);
      hold(1'b0, 10);
      chk("released_btn_db", int'(btn_db), 0);

      // bounce: 1,1,0,1,1,0 then quiet -> ignored
      bounce = 6'b011011;
      for (int i = 0; i < 6; i++) hold(bounce[i], 1);
      hold(1'b0, 10);
      chk("bounce_btn_db", int'(btn_db), 0);
      chk("bounce_mode", int'(mode), 1);

      // second press returns mode to 0
      press(1'b0, 8);
      hold(1'b0, 8);

      // locked press: pulse but no toggle
      lock = 1'b1;
      press(1'b0, 10);
      hold(1'b0, 10);
      lock = 1'b0;
      chk("locked_mode", int'(mode), 0);

      // unlocked press toggles; lock flips after acceptance have no effect
      press(1'b1, 8);
      lock = 1'b1;
      hold(1'b1, 2);
      hold(1'b0, 10);
      lock = 1'b0;
      chk("post_lock_mode", int'(mode), 1);

      // long hold with a 2-cycle release glitch: one toggle only
      press(1'b0, 50);
      hold(1'b0, 2);
      hold(1'b1, 48);
      hold(1'b0, 10);
      chk("long_hold_mode", int'(mode), 0);

      // bring mode to 1 before the reset test
      press(1'b1, 8);
      hold(1'b0, 10);

      // async reset mid DEB_HI (cnt=2), btn kept high
      hold(1'b1, 4);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_mode", int'(mode), 0);
      chk("async_rst_btn_db", int'(btn_db), 0);
      chk("async_rst_pulse", int'(press_pulse), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      press(1'b1, 10);
      hold(1'b0, 10);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      chk("pending_presses", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
